// File: rtl/tdc_meas_pkg.sv
// Shared constants and FSM state type for the TDC interval-measurement controller.
// Latency: n/a (declarations only).
// Backpressure: n/a; the controller has no stall path and waits indefinitely for the TDC.
package tdc_meas_pkg;

    // Default widths; COARSE_W + 2*FINE_W must fill the 64-bit result exactly.
    localparam int TDC_COARSE_W    = 8;
    localparam int TDC_FINE_W      = 28;
    localparam int TDC_SYNC_STAGES = 2;
    localparam int TDC_RESULT_W    = 64;

    // Result layout, MSB first: {coarse, fine_start, fine_stop}.
    localparam int TDC_FINE_STOP_LSB  = 0;
    localparam int TDC_FINE_START_LSB = TDC_FINE_W;
    localparam int TDC_COARSE_LSB     = 2 * TDC_FINE_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM1    = 3'd1,
        ST_WAIT_A1 = 3'd2,
        ST_COUNT   = 3'd3,
        ST_ARM2    = 3'd4,
        ST_WAIT_A2 = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/tdc_sync_edge.sv
// Flop-chain synchronizer for an asynchronous level plus a registered rising-edge pulse.
// Latency: pulse is high for one cycle, STAGES+1 clk edges after async_in rises.
// Backpressure: none; every rising edge of the synchronized level yields exactly one pulse.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   async_in  asynchronous input level (treated as data)
//   pulse     one-cycle rising-edge pulse in the clk domain
module tdc_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            // Shift towards the MSB; bit 0 is the metastability-exposed flop.
            sync_q <= (sync_q << 1) | STAGES'(async_in);
            last_q <= sync_q[STAGES-1];
            pulse  <= sync_q[STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Interval-measurement controller for an external TDC: gates start/stop to clk_i edges,
// counts coarse clk_i periods, captures fine results and emits a packed 64-bit result.
// Latency: strobes SYNC_STAGES+2 clk after the async input rises; done one cycle after the
// second AluTriger. Backpressure: none; waits indefinitely for AluTriger, no timeout.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   clk_i, start, stop  asynchronous reference signal and measurement events
//   AluTriger, data_in  one-cycle strobe with a valid fine TDC result
//   TDC_start, TDC_stop one-cycle strobes to the TDC chip
//   timedata, done      {coarse, fine_start, fine_stop} and its one-cycle update strobe
module tdc_meas_ctrl
    import tdc_meas_pkg::*;
#(
    parameter int COARSE_W    = TDC_COARSE_W,
    parameter int FINE_W      = TDC_FINE_W,
    parameter int SYNC_STAGES = TDC_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clk_i,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    AluTriger,
    input  logic [FINE_W-1:0]       data_in,
    output logic                    TDC_start,
    output logic                    TDC_stop,
    output logic [TDC_RESULT_W-1:0] timedata,
    output logic                    done
);

    localparam logic [COARSE_W-1:0] COARSE_MAX = '1;

    logic clk_pls;
    logic start_pls;
    logic stop_pls;

    state_t              state;
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine_start;
    logic [FINE_W-1:0]   fine_stop;
    logic                stop_pend;

    tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (clk_i),
        .pulse    (clk_pls)
    );

    tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (start),
        .pulse    (start_pls)
    );

    tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stop (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (stop),
        .pulse    (stop_pls)
    );

    function automatic logic [COARSE_W-1:0] sat_inc(input logic [COARSE_W-1:0] v);
        return (v == COARSE_MAX) ? v : v + COARSE_W'(1);
    endfunction

    // All inputs to the FSM share the same synchronizer latency, so the relative
    // ordering of start/stop/clk_i edges is preserved. AluTriger is already synchronous.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            coarse     <= '0;
            fine_start <= '0;
            fine_stop  <= '0;
            stop_pend  <= 1'b0;
            TDC_start  <= 1'b0;
            TDC_stop   <= 1'b0;
            timedata   <= '0;
            done       <= 1'b0;
        end else begin
            TDC_start <= 1'b0;
            TDC_stop  <= 1'b0;
            done      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    stop_pend <= 1'b0;
                    // A clk_i edge coinciding with start is not eligible as the gated edge:
                    // ARM1 only looks at clk_i from the following cycle.
                    if (start_pls) begin
                        TDC_start <= 1'b1;
                        state     <= ST_ARM1;
                    end
                end

                ST_ARM1: begin
                    if (clk_pls) begin
                        TDC_stop <= 1'b1;
                        coarse   <= '0;
                        state    <= ST_WAIT_A1;
                    end
                end

                ST_WAIT_A1: begin
                    // Periods keep elapsing while the TDC converts; count them here too.
                    if (clk_pls) begin
                        coarse <= sat_inc(coarse);
                    end
                    // A stop that arrives before the first fine result is remembered and
                    // acted on as soon as COUNT is entered.
                    if (stop_pls) begin
                        stop_pend <= 1'b1;
                    end
                    if (AluTriger) begin
                        fine_start <= data_in;
                        state      <= ST_COUNT;
                    end
                end

                ST_COUNT: begin
                    // A clk_i edge in the same cycle as stop still belongs to COUNT;
                    // the gated stop edge is the next one, seen in ARM2.
                    if (clk_pls) begin
                        coarse <= sat_inc(coarse);
                    end
                    if (stop_pls || stop_pend) begin
                        stop_pend <= 1'b0;
                        TDC_start <= 1'b1;
                        state     <= ST_ARM2;
                    end
                end

                ST_ARM2: begin
                    if (clk_pls) begin
                        coarse   <= sat_inc(coarse);
                        TDC_stop <= 1'b1;
                        state    <= ST_WAIT_A2;
                    end
                end

                ST_WAIT_A2: begin
                    if (AluTriger) begin
                        fine_stop <= data_in;
                        state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    timedata <= {coarse, fine_start, fine_stop};
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl: random-gap measurements checked against an
// event-timeline model of gated edges, coarse counts, strobe cycles and packed results.
// Bench only; not synthesizable.
module tb_tdc_meas_ctrl;
    import tdc_meas_pkg::*;

    // Async input rising first sampled at edge k is acted on by the FSM at edge k+LAT.
    localparam int LAT  = TDC_SYNC_STAGES + 1;
    localparam int NONE = 1 << 28;

    logic                  clk       = 1'b0;
    logic                  reset_n   = 1'b0;
    logic                  clk_i     = 1'b0;
    logic                  start     = 1'b0;
    logic                  stop      = 1'b0;
    logic                  AluTriger = 1'b0;
    logic [TDC_FINE_W-1:0] data_in   = '0;
    logic                  TDC_start;
    logic                  TDC_stop;
    logic [63:0]           timedata;
    logic                  done;

    tdc_meas_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_i     (clk_i),
        .start     (start),
        .stop      (stop),
        .AluTriger (AluTriger),
        .data_in   (data_in),
        .TDC_start (TDC_start),
        .TDC_stop  (TDC_stop),
        .timedata  (timedata),
        .done      (done)
    );

    // clk period 20 units; clk_i period 90 units, edges never coincide with clk edges.
    initial forever #10 clk = ~clk;
    initial begin
        #3;
        forever #45 clk_i = ~clk_i;
    end

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int overlap = 0;

    int clk_q[$];
    int start_q[$];
    int stop_q[$];
    int alu_q[$];
    int tstart_q[$];
    int tstop_q[$];
    int done_q[$];

    logic        ci_d = 1'b0;
    logic        st_d = 1'b0;
    logic        sp_d = 1'b0;
    logic [63:0] td_done  = '0;
    logic [63:0] last_exp = '0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Input timeline: records the FSM cycle at which each event becomes effective.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (clk_i && !ci_d) clk_q.push_back(cyc + LAT);
        if (start && !st_d) start_q.push_back(cyc + LAT);
        if (stop && !sp_d)  stop_q.push_back(cyc + LAT);
        if (AluTriger)      alu_q.push_back(cyc);
        ci_d = clk_i;
        st_d = start;
        sp_d = stop;
    end

    // Output observation, away from the active edge.
    always @(negedge clk) begin
        if (TDC_start) tstart_q.push_back(cyc);
        if (TDC_stop)  tstop_q.push_back(cyc);
        if (done) begin
            done_q.push_back(cyc);
            td_done = timedata;
        end
        if (TDC_start && TDC_stop) overlap++;
    end

    function automatic int first_after(input int q[$], input int t);
        foreach (q[i]) if (q[i] > t) return q[i];
        return NONE;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_obs();
        clk_q.delete();
        start_q.delete();
        stop_q.delete();
        alu_q.delete();
        tstart_q.delete();
        tstop_q.delete();
        done_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        #30;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        #30;
        stop = 1'b0;
    endtask

    task automatic pulse_alu(input logic [TDC_FINE_W-1:0] d);
        @(posedge clk);
        #2;
        AluTriger = 1'b1;
        data_in   = d;
        @(posedge clk);
        #2;
        AluTriger = 1'b0;
        data_in   = TDC_FINE_W'($urandom);
    endtask

    // mode 0: stop after a given gap; 1: stop before the first AluTriger;
    // 2: stop placed so that exactly 10 clk_i edges are counted.
    task automatic run_meas(input string name, input int mode, input int gap,
                            input logic [TDC_FINE_W-1:0] f1, input logic [TDC_FINE_W-1:0] f2,
                            input bit extra_start);
        int sp, g1, stp, a1, eff, g2, a2, coarse, n;
        logic [63:0] exp;
        @(posedge clk);
        #2;
        clear_obs();
        pulse_start();
        if (mode == 1) begin
            #250;
            pulse_stop();
            #300;
            pulse_alu(f1);
        end else begin
            #370;
            pulse_alu(f1);
            if (mode == 2) begin
                n = 0;
                for (int i = 0; i < 400 && n < 10; i++) begin
                    @(posedge clk);
                    #2;
                    n = 0;
                    foreach (clk_q[j]) if (start_q.size() > 0 && clk_q[j] > start_q[0]) n++;
                end
            end else begin
                if (extra_start) begin
                    #(gap / 2);
                    pulse_start();
                    #(gap / 2);
                end else begin
                    #(gap);
                end
                @(posedge clk);
                #2;
            end
            pulse_stop();
        end
        #400;
        pulse_alu(f2);
        for (int i = 0; i < 40 && done_q.size() == 0; i++) @(negedge clk);
        repeat (5) @(posedge clk);
        #2;

        // Reference: gated edges are the first clk_i events strictly after the start and
        // (effective) stop events; coarse counts clk_i events in (gate1, gate2].
        sp  = qget(start_q, 0);
        g1  = first_after(clk_q, sp);
        stp = first_after(stop_q, g1);
        a1  = first_after(alu_q, g1);
        eff = (stp > a1 + 1) ? stp : a1 + 1;
        g2  = first_after(clk_q, eff);
        a2  = first_after(alu_q, g2);
        coarse = 0;
        foreach (clk_q[j]) if (clk_q[j] > g1 && clk_q[j] <= g2) coarse++;
        if (coarse > 255) coarse = 255;
        exp = {coarse[7:0], f1, f2};

        chk_eq({name, "_ndone"},    done_q.size(), 1);
        chk_eq({name, "_done_cyc"}, qget(done_q, 0), a2 + 1);
        chk_eq({name, "_timedata"}, td_done, exp);
        chk_eq({name, "_nstart"},   tstart_q.size(), 2);
        chk_eq({name, "_start0"},   qget(tstart_q, 0), sp);
        chk_eq({name, "_start1"},   qget(tstart_q, 1), eff);
        chk_eq({name, "_nstop"},    tstop_q.size(), 2);
        chk_eq({name, "_stop0"},    qget(tstop_q, 0), g1);
        chk_eq({name, "_stop1"},    qget(tstop_q, 1), g2);
        chk_eq({name, "_held"},     timedata, exp);
        last_exp = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_eq("rst_tdc_start", TDC_start, 0);
        chk_eq("rst_tdc_stop",  TDC_stop,  0);
        chk_eq("rst_done",      done,      0);
        chk_eq("rst_timedata",  timedata,  0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        #400;

        run_meas("basic", 2, 0, 28'd1203, 28'd500, 1'b0);
        chk_eq("basic_const", td_done, 64'h0A00004B300001F4);

        run_meas("early", 1, 0, 28'h1234567, 28'h0ABCDEF, 1'b0);

        // Spurious events in IDLE: nothing should move.
        clear_obs();
        pulse_alu(28'd123);
        pulse_stop();
        #1000;
        chk_eq("idle_nstart", tstart_q.size(), 0);
        chk_eq("idle_nstop",  tstop_q.size(),  0);
        chk_eq("idle_ndone",  done_q.size(),   0);
        chk_eq("idle_td",     timedata,        last_exp);

        run_meas("xstart", 0, 3000, TDC_FINE_W'($urandom), TDC_FINE_W'($urandom), 1'b1);

        // Reset in the middle of a measurement aborts it.
        @(posedge clk);
        #2;
        clear_obs();
        pulse_start();
        #370;
        pulse_alu(28'd77);
        #500;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(negedge clk);
        chk_eq("mid_rst_tdc_start", TDC_start, 0);
        chk_eq("mid_rst_tdc_stop",  TDC_stop,  0);
        chk_eq("mid_rst_done",      done,      0);
        chk_eq("mid_rst_timedata",  timedata,  0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        clear_obs();
        #1000;
        pulse_stop();
        #200;
        pulse_alu(28'd5);
        #600;
        chk_eq("post_rst_ndone",  done_q.size(),   0);
        chk_eq("post_rst_nstart", tstart_q.size(), 0);
        chk_eq("post_rst_nstop",  tstop_q.size(),  0);
        chk_eq("post_rst_td",     timedata,        0);

        run_meas("after_rst", 2, 0, 28'd1203, 28'd500, 1'b0);
        chk_eq("after_rst_const", td_done, 64'h0A00004B300001F4);

        for (int m = 0; m < 10; m++) begin
            run_meas($sformatf("b2b%0d", m), 0, int'($urandom_range(6000, 2000)),
                     28'd1203, 28'd1203, 1'b0);
            #(int'($urandom_range(300, 100)));
        end

        run_meas("sat", 0, 27500, 28'd1203, 28'd500, 1'b0);
        chk_eq("sat_coarse", td_done[63:56], 8'hFF);

        chk_eq("strobe_excl", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
- Controller for an interval measurement built around an external TDC chip.
- Gates `start`/`stop` events to the first following rising edge of the reference signal `clk_i`, and drives the TDC start/stop strobes.
- Counts whole `clk_i` periods between the two gated edges as the coarse time.
- Captures the TDC fine results from `data_in` when `AluTriger` strobes, then emits one packed 64-bit result with a `done` pulse.

Parameters:
- COARSE_W, 8, coarse counter width. Saturating.
- FINE_W, 28, width of each fine TDC value.
- SYNC_STAGES, 2, synchronizer depth for `clk_i`, `start` and `stop`.
- Constraint: COARSE_W + 2*FINE_W = 64.

Ports:
- clk  in  1  single system clock (50 MHz nominal). All logic rises on it.
- reset_n  in  1  asynchronous, active-low reset.
- clk_i  in  1  reference signal (~11 MHz), asynchronous. Sampled as data, never used as a clock.
- start  in  1  async measurement-start event. High for at least 1 clk period.
- stop  in  1  async measurement-stop event. High for at least 1 clk period.
- AluTriger  in  1  synchronous 1-cycle strobe: `data_in` holds a valid fine result.
- data_in  in  FINE_W  fine time from the TDC.
- TDC_start  out  1  1-cycle strobe to the TDC start input.
- TDC_stop  out  1  1-cycle strobe marking the gated `clk_i` edge.
- timedata  out  64  result: {coarse, fine_start, fine_stop}.
- done  out  1  1-cycle strobe: `timedata` updated.

Behaviour:
- **Reset:** all outputs 0, counters 0, FSM in IDLE. Reset mid-measurement aborts it with no `done`.
- **Synchronization:** `clk_i`, `start` and `stop` each pass through a SYNC_STAGES flop chain, then a rising-edge detector.
  - A detected edge is a 1-cycle internal pulse, SYNC_STAGES+1 clk edges after the input rises.
  - Registered strobes appear one cycle after the detected edge.
- **FSM states:** IDLE, ARM1, WAIT_A1, COUNT, ARM2, WAIT_A2, DONE.
  - IDLE: a `start` edge pulses TDC_start, goes to ARM1.
  - ARM1: the next `clk_i` edge pulses TDC_stop, clears coarse to 0, goes to WAIT_A1.
  - WAIT_A1: `AluTriger` latches `data_in` into fine_start, goes to COUNT.
  - COUNT: each `clk_i` edge increments coarse. A `stop` edge pulses TDC_start, goes to ARM2.
  - ARM2: the next `clk_i` edge increments coarse, pulses TDC_stop, goes to WAIT_A2.
  - WAIT_A2: `AluTriger` latches `data_in` into fine_stop, goes to DONE.
  - DONE (one cycle): `timedata <= {coarse, fine_start, fine_stop}`, `done` = 1, return to IDLE.
- **Coarse counting:**
  - `clk_i` edges are also counted during WAIT_A1.
  - A `stop` edge in WAIT_A1 sets a pending flag. COUNT consumes the flag on entry exactly as if `stop` arrived then.
  - Coarse = number of `clk_i` rising edges after the first gated edge, up to and including the second gated edge. It saturates at all-ones.
- **Ignored events:**
  - `start` edges outside IDLE.
  - `stop` edges in IDLE, ARM1 and ARM2.
  - `stop` edges in WAIT_A2.
  - `AluTriger` outside WAIT_A1 and WAIT_A2.
- **Simultaneous events:**
  - A `clk_i` edge in the same cycle as the `stop` edge in COUNT is counted as a COUNT edge. The gated edge is the next one.
  - A `clk_i` edge in the same cycle as a `start` edge in IDLE is not the gated edge.
- **Output holding:** `timedata` holds its value until the next DONE. There is no timeout; the FSM waits indefinitely for `AluTriger`.
- **Strobe exclusivity:** TDC_start and TDC_stop are never high in the same cycle.

Decomposition:
- **Package tdc_meas_pkg:**
  - COARSE_W, FINE_W, SYNC_STAGES constants.
  - FSM state enum.
  - Result pack function or concatenation order.
- **Sub-module tdc_sync_edge:** parameterized flop synchronizer plus rising-edge pulse. Instantiated three times, for `clk_i`, `start` and `stop`.

Test Plan:
- **Reset:** assert reset_n=0 mid-measurement, then release → all outputs 0, FSM in IDLE. The next full measurement produces a correct `done`.
- **Basic measurement:** `start` 30 ns, then AluTriger with data_in=1203, then `stop` such that exactly 10 `clk_i` edges are counted, then AluTriger with data_in=500 → `done` is 1 cycle and timedata=0x0A00004B300001F4.
- **Strobe timing:** `start` pulse → TDC_start is 1 cycle, SYNC_STAGES+2 clk after `start` rises. TDC_stop is 1 cycle, SYNC_STAGES+2 clk after the next `clk_i` rise.
- **Early stop:** `stop` edge before the first AluTriger → pending flag honored, coarse correct, `done` asserted after the second AluTriger.
- **Spurious inputs:** extra `start` during COUNT, AluTriger in IDLE, `stop` in IDLE → no state change, no strobes, timedata unchanged.
- **Back-to-back and saturation:**
  - 10 back-to-back measurements with data_in=1203 and random 2–6 µs gaps → 10 `done` pulses, each coarse = gated-edge count (±0 vs. a bench model counting `clk_i` rises).
  - A 300-period gap → coarse = 255.
